polyphase_decim_ctrl: RTL

- Sequencer for a polyphase decimate-by-NR_PHASES FIR built from NR_PHASES subfilter instances, each running the req/ack sample handshake.
- Takes the upstream sample stream and commutates consecutive samples to the phases.
- Waits for every phase to finish its multiply-accumulate, acknowledges all phase outputs together, sums them and offers one decimated sample downstream.
- Sits between the sample source and the subfilter bank, and between the bank and the sink.

---
 rtl/polyphase_decim_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/polyphase_decim_ctrl.sv
// polyphase_decim_ctrl
// Sequencer for a polyphase decimate-by-NR_PHASES FIR. It commutates upstream
// samples onto the subfilter bank, with the newest sample going to phase 0.
// It then collects all phase outputs in one cycle, sums them and offers the
// decimated sample downstream.
//
// Optional feature: define POLYPHASE_DECIM_CTRL_SAT_EN to clamp the phase sum
// to the DWIDTH signed range. Otherwise the sum wraps in two's complement.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   req_in/ack_in   upstream sample handshake, data_in sample ([0:DWIDTH-1])
//   req_out/ack_out downstream handshake, data_out decimated sample (registered)
//   sf_req_in       per-phase "ready for a sample"
//   sf_ack_in       per-phase one-cycle sample strobe
//   sf_data_in      shared registered sample bus
//   sf_req_out      per-phase "output ready"
//   sf_ack_out      per-phase one-cycle output acknowledge
//   sf_data_out     phase outputs, phase p at p*DWIDTH +: DWIDTH
//   busy            low only while a decimated sample is being offered
module polyphase_decim_ctrl #(
    parameter int NR_PHASES = 2,
    parameter int DWIDTH    = 16,
    parameter int PWIDTH    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          req_in,
    input  logic                          ack_in,
    input  logic [0:DWIDTH-1]             data_in,
    output logic                          req_out,
    input  logic                          ack_out,
    output logic [DWIDTH-1:0]             data_out,
    input  logic [NR_PHASES-1:0]          sf_req_in,
    output logic [NR_PHASES-1:0]          sf_ack_in,
    output logic [DWIDTH-1:0]             sf_data_in,
    input  logic [NR_PHASES-1:0]          sf_req_out,
    output logic [NR_PHASES-1:0]          sf_ack_out,
    input  logic [NR_PHASES*DWIDTH-1:0]   sf_data_out,
    output logic                          busy
);
    typedef enum logic [1:0] {S_WAIT, S_COLLECT, S_OUT, S_FILL} state_t;

    localparam int SW = DWIDTH + PWIDTH;
    localparam logic [PWIDTH-1:0] LAST_PHASE = PWIDTH'(NR_PHASES - 1);
    localparam logic signed [SW-1:0] MAX_V = {{(PWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(PWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    state_t state, state_nxt;
    logic [PWIDTH-1:0] phase;
    logic              req_in_nxt;
    logic [NR_PHASES-1:0] phase_hot;
    logic [2**PWIDTH-1:0] req_pad;
    logic signed [SW-1:0] sum_wide;
    logic [DWIDTH-1:0]    sum_red;

    // Zero-pad the request vector so the phase counter indexes it at full width.
    always_comb begin
        req_pad = '0;
        req_pad[NR_PHASES-1:0] = sf_req_in;
    end

    always_comb begin
        phase_hot = '0;
        for (int i = 0; i < NR_PHASES; i++)
            phase_hot[i] = (phase == PWIDTH'(i));
    end

    // PWIDTH guard bits make the wide sum exact for up to 2^PWIDTH phases.
    always_comb begin
        sum_wide = '0;
        for (int i = 0; i < NR_PHASES; i++)
            sum_wide = sum_wide + SW'(signed'(sf_data_out[i*DWIDTH +: DWIDTH]));
    end

`ifdef POLYPHASE_DECIM_CTRL_SAT_EN
    always_comb begin
        if (sum_wide > MAX_V)
            sum_red = MAX_V[DWIDTH-1:0];
        else if (sum_wide < MIN_V)
            sum_red = MIN_V[DWIDTH-1:0];
        else
            sum_red = sum_wide[DWIDTH-1:0];
    end
`else
    always_comb sum_red = sum_wide[DWIDTH-1:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_WAIT;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:    if (&sf_req_out) state_nxt = S_COLLECT;
            S_COLLECT: state_nxt = S_OUT;
            S_OUT:     if (ack_out) state_nxt = S_FILL;
            S_FILL:    if ((|sf_ack_in) && phase == '0) state_nxt = S_WAIT;
            default:   state_nxt = S_WAIT;
        endcase
    end

    // Output logic. req_in is registered. A cycle with ack_in high, or with an
    // sf_ack_in strobe, blocks the next request. This gives at least three
    // cycles per sample and keeps req_in low across every sample boundary.
    always_comb begin
        sf_ack_out = {NR_PHASES{state == S_COLLECT}};
        busy       = (state != S_OUT);
        req_in_nxt = (state == S_FILL) && req_pad[phase] && !(|sf_ack_in) && !ack_in;
    end

    // Datapath and handshake registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_in     <= 1'b0;
            req_out    <= 1'b0;
            sf_ack_in  <= '0;
            sf_data_in <= '0;
            data_out   <= '0;
            phase      <= LAST_PHASE;
        end else begin
            req_in    <= req_in_nxt;
            sf_ack_in <= '0;
            case (state)
                S_COLLECT: begin
                    data_out <= sum_red;
                    req_out  <= 1'b1;
                end
                S_OUT: if (ack_out) begin
                    req_out <= 1'b0;
                    phase   <= LAST_PHASE;
                end
                S_FILL: begin
                    if (req_in && ack_in) begin
                        sf_data_in <= data_in;
                        sf_ack_in  <= phase_hot;
                    end else if ((|sf_ack_in) && phase != '0) begin
                        phase <= phase - PWIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
